load_use_stall_ctrl: RTL and testbench
======================================

Name: load_use_stall_ctrl

Overview:
- Pipeline hazard scheduler sitting between the ID stage and the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards that forwarding cannot cover and holds PC and IF/ID for a configurable number of cycles.
- Injects bubbles into ID/EX during those cycles.
- Sequences taken-branch flushes and keeps saturating event counters for performance debug.

Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge
- Rst_n  input  1  asynchronous active-low reset
- rs_address_ID  input  5  rs field of the instruction in ID
- rt_address_ID  input  5  rt field of the instruction in ID
- UsesRt_ID  input  1  1 = ID instruction reads rt as a source
- MemRead_EX  input  1  instruction in EX is a load
- RegDstResult_EX  input  5  destination register of the EX instruction
- BranchTaken_EX  input  1  branch resolved taken in EX this cycle
- PCWrite  output  1  1 = PC may update
- IFIDWrite  output  1  1 = IF/ID may load
- ID_Bubble  output  1  1 = zero the control bits entering ID/EX
- IF_Flush  output  1  1 = clear IF/ID (instruction becomes nop)
- Busy  output  1  1 while in STALL state
- stall_total  output  CNT_W  cycles with PCWrite=0, saturating
- flush_total  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state = IDLE, cnt = 0, stall_total = 0, flush_total = 0.
  - While Rst_n is low, outputs are forced to PCWrite=1, IFIDWrite=1, ID_Bubble=0, IF_Flush=0, Busy=0, regardless of inputs.
  - Reset mid-stall aborts the stall immediately.
- Hazard term (combinational): hz = MemRead_EX && RegDstResult_EX != 0 && (RegDstResult_EX == rs_address_ID || (UsesRt_ID && RegDstResult_EX == rt_address_ID)). Register 0 never causes a hazard.
- Outputs are Mealy: a function of the current state and the current inputs, with zero-cycle latency. The stall must take effect in the same cycle the hazard is seen.
- IDLE state:
  - BranchTaken_EX=1 has priority over hz.
    - Outputs IF_Flush=1, ID_Bubble=1, PCWrite=1, IFIDWrite=1.
    - flush_total += 1. Next state IDLE.
  - Else if hz=1:
    - Outputs PCWrite=0, IFIDWrite=0, ID_Bubble=1. stall_total += 1.
    - If STALL_CYCLES==1, next state IDLE.
    - Else next state STALL with cnt = STALL_CYCLES-1.
  - Else: PCWrite=1, IFIDWrite=1, ID_Bubble=0, IF_Flush=0.
- STALL state:
  - Busy=1. hz is ignored, because the load has advanced and the stall is held by the count.
  - Outputs PCWrite=0, IFIDWrite=0, ID_Bubble=1, IF_Flush=0. stall_total += 1.
  - cnt decrements each cycle. When cnt==1 at the edge, next state is IDLE; otherwise stay in STALL.
  - BranchTaken_EX=1 in STALL (not expected architecturally):
    - Abort the stall. Outputs as in the IDLE branch case; flush_total += 1; stall_total is unchanged.
    - Next state IDLE, cnt = 0.
- Total bubble cycles per hazard = STALL_CYCLES exactly, counting the detect cycle.
- The first cycle back in IDLE re-evaluates hz, so back-to-back hazards produce a fresh stall with no gap cycle.
- Counters saturate at all-ones and never wrap.
- Simultaneous branch and hz in IDLE: flush only; no stall, no stall_total increment.

Test Plan:
- Reset, then MemRead_EX=1, RegDstResult_EX=8, rs_address_ID=8, STALL_CYCLES=1 -> same cycle PCWrite=0, IFIDWrite=0, ID_Bubble=1; next cycle, with MemRead_EX=0, all back to 1/1/0; stall_total=1.
- STALL_CYCLES=3, hazard on rt=9 with UsesRt_ID=1 -> exactly 3 consecutive cycles PCWrite=0, Busy=1 on cycles 2-3 only; stall_total=3. Same case with UsesRt_ID=0 -> no stall.
- RegDstResult_EX=0 with rs_address_ID=0 and MemRead_EX=1 -> no stall; stall_total stays 0.
- BranchTaken_EX=1 together with hz=1 in IDLE -> IF_Flush=1, ID_Bubble=1, PCWrite=1; flush_total=1, stall_total=0.
- STALL_CYCLES=4, assert Rst_n=0 during the 2nd stall cycle -> outputs return to PCWrite=1, Busy=0 without waiting for a clock; counters = 0. Separately, inject BranchTaken_EX in STALL -> stall aborts and state returns to IDLE.
- Force stall_total to all-ones via a long hazard sequence with CNT_W overridden to 4 -> the counter holds at 15 with no wrap.

Source files
------------

// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard scheduler: holds PC and IF/ID for STALL_CYCLES cycles per load-use hazard,
// sequences taken-branch flushes and keeps saturating stall/flush counters.
module load_use_stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       rs_address_ID,
    input  logic [4:0]       rt_address_ID,
    input  logic             UsesRt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RegDstResult_EX,
    input  logic             BranchTaken_EX,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             ID_Bubble,
    output logic             IF_Flush,
    output logic             Busy,
    output logic [CNT_W-1:0] stall_total,
    output logic [CNT_W-1:0] flush_total
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       hz;
    logic       pc_write, ifid_write, id_bubble, if_flush, busy;
    logic       stall_inc, flush_inc;

    assign hz = MemRead_EX && (RegDstResult_EX != 5'd0) &&
                ((RegDstResult_EX == rs_address_ID) ||
                 (UsesRt_ID && (RegDstResult_EX == rt_address_ID)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            stall_total <= '0;
            flush_total <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (stall_inc && (stall_total != {CNT_W{1'b1}}))
                stall_total <= stall_total + CNT_W'(1);
            if (flush_inc && (flush_total != {CNT_W{1'b1}}))
                flush_total <= flush_total + CNT_W'(1);
        end
    end

    // Mealy decode: the stall must act in the same cycle the hazard is seen.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        id_bubble  = 1'b0;
        if_flush   = 1'b0;
        busy       = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (BranchTaken_EX) begin
                    if_flush  = 1'b1;
                    id_bubble = 1'b1;
                    flush_inc = 1'b1;
                end else if (hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    id_bubble  = 1'b1;
                    stall_inc  = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        next_state = STALL;
                        next_cnt   = 4'(STALL_CYCLES - 1);
                    end
                end
            end
            STALL: begin
                busy = 1'b1;
                if (BranchTaken_EX) begin
                    if_flush   = 1'b1;
                    id_bubble  = 1'b1;
                    flush_inc  = 1'b1;
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    id_bubble  = 1'b1;
                    stall_inc  = 1'b1;
                    next_cnt   = cnt - 4'd1;
                    if (cnt == 4'd1)
                        next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Reset forces a safe free-running pipeline without waiting for a clock.
    assign PCWrite   = Rst_n ? pc_write   : 1'b1;
    assign IFIDWrite = Rst_n ? ifid_write : 1'b1;
    assign ID_Bubble = Rst_n ? id_bubble  : 1'b0;
    assign IF_Flush  = Rst_n ? if_flush   : 1'b0;
    assign Busy      = Rst_n ? busy       : 1'b0;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed self-checking bench for load_use_stall_ctrl; four instances cover
// STALL_CYCLES of 1, 3 and 4 and a narrow counter for saturation.
module tb_load_use_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] rs_address_ID, rt_address_ID, RegDstResult_EX;
    logic       UsesRt_ID, MemRead_EX, BranchTaken_EX;

    logic        pc1, ifid1, bub1, flush1, busy1;
    logic [31:0] stall1, flushCnt1;
    logic        pc3, ifid3, bub3, flush3, busy3;
    logic [31:0] stall3, flushCnt3;
    logic        pc4, ifid4, bub4, flush4, busy4;
    logic [31:0] stall4, flushCnt4;
    logic        pcS, ifidS, bubS, flushS, busyS;
    logic [3:0]  stallS, flushCntS;

    int assertCount = 0;
    int failCount   = 0;

    always #5 Clk = ~Clk;

    load_use_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .rs_address_ID(rs_address_ID), .rt_address_ID(rt_address_ID),
        .UsesRt_ID(UsesRt_ID), .MemRead_EX(MemRead_EX), .RegDstResult_EX(RegDstResult_EX),
        .BranchTaken_EX(BranchTaken_EX), .PCWrite(pc1), .IFIDWrite(ifid1), .ID_Bubble(bub1),
        .IF_Flush(flush1), .Busy(busy1), .stall_total(stall1), .flush_total(flushCnt1));

    load_use_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(32)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .rs_address_ID(rs_address_ID), .rt_address_ID(rt_address_ID),
        .UsesRt_ID(UsesRt_ID), .MemRead_EX(MemRead_EX), .RegDstResult_EX(RegDstResult_EX),
        .BranchTaken_EX(BranchTaken_EX), .PCWrite(pc3), .IFIDWrite(ifid3), .ID_Bubble(bub3),
        .IF_Flush(flush3), .Busy(busy3), .stall_total(stall3), .flush_total(flushCnt3));

    load_use_stall_ctrl #(.STALL_CYCLES(4), .CNT_W(32)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .rs_address_ID(rs_address_ID), .rt_address_ID(rt_address_ID),
        .UsesRt_ID(UsesRt_ID), .MemRead_EX(MemRead_EX), .RegDstResult_EX(RegDstResult_EX),
        .BranchTaken_EX(BranchTaken_EX), .PCWrite(pc4), .IFIDWrite(ifid4), .ID_Bubble(bub4),
        .IF_Flush(flush4), .Busy(busy4), .stall_total(stall4), .flush_total(flushCnt4));

    load_use_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) dutSat (
        .Clk(Clk), .Rst_n(Rst_n), .rs_address_ID(rs_address_ID), .rt_address_ID(rt_address_ID),
        .UsesRt_ID(UsesRt_ID), .MemRead_EX(MemRead_EX), .RegDstResult_EX(RegDstResult_EX),
        .BranchTaken_EX(BranchTaken_EX), .PCWrite(pcS), .IFIDWrite(ifidS), .ID_Bubble(bubS),
        .IF_Flush(flushS), .Busy(busyS), .stall_total(stallS), .flush_total(flushCntS));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Inputs change just after a rising edge and settle before outputs are sampled.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic memRead, input logic [4:0] dst, input logic branch);
        rs_address_ID   = rs;
        rt_address_ID   = rt;
        UsesRt_ID       = usesRt;
        MemRead_EX      = memRead;
        RegDstResult_EX = dst;
        BranchTaken_EX  = branch;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic resetDut();
        Rst_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        // Reset with a hazard and a branch both present: outputs must stay forced safe.
        Rst_n = 1'b0;
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        checkOutput("rst_pcwrite", {31'd0, pc1}, 32'd1);
        checkOutput("rst_ifidwrite", {31'd0, ifid1}, 32'd1);
        checkOutput("rst_bubble", {31'd0, bub1}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush1}, 32'd0);
        checkOutput("rst_stall_total", stall1, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        nextCycle();

        // Single-cycle stall on rs match.
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        checkOutput("sc1_pcwrite", {31'd0, pc1}, 32'd0);
        checkOutput("sc1_ifidwrite", {31'd0, ifid1}, 32'd0);
        checkOutput("sc1_bubble", {31'd0, bub1}, 32'd1);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0);
        checkOutput("sc1_after_pcwrite", {31'd0, pc1}, 32'd1);
        checkOutput("sc1_after_ifidwrite", {31'd0, ifid1}, 32'd1);
        checkOutput("sc1_after_bubble", {31'd0, bub1}, 32'd0);
        checkOutput("sc1_stall_total", stall1, 32'd1);

        // Three-cycle stall on rt match; Busy only in cycles 2 and 3.
        resetDut();
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        checkOutput("sc3_c1_pcwrite", {31'd0, pc3}, 32'd0);
        checkOutput("sc3_c1_busy", {31'd0, busy3}, 32'd0);
        nextCycle();
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0);
        checkOutput("sc3_c2_pcwrite", {31'd0, pc3}, 32'd0);
        checkOutput("sc3_c2_busy", {31'd0, busy3}, 32'd1);
        nextCycle();
        checkOutput("sc3_c3_pcwrite", {31'd0, pc3}, 32'd0);
        checkOutput("sc3_c3_busy", {31'd0, busy3}, 32'd1);
        checkOutput("sc3_c3_bubble", {31'd0, bub3}, 32'd1);
        nextCycle();
        checkOutput("sc3_c4_pcwrite", {31'd0, pc3}, 32'd1);
        checkOutput("sc3_c4_busy", {31'd0, busy3}, 32'd0);
        checkOutput("sc3_stall_total", stall3, 32'd3);
        applyStimulus(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        checkOutput("sc3_nort_pcwrite", {31'd0, pc3}, 32'd1);
        nextCycle();
        checkOutput("sc3_nort_stall_total", stall3, 32'd3);

        // Register zero never hazards.
        resetDut();
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        checkOutput("r0_pcwrite", {31'd0, pc1}, 32'd1);
        checkOutput("r0_bubble", {31'd0, bub1}, 32'd0);
        nextCycle();
        checkOutput("r0_stall_total", stall1, 32'd0);

        // Branch beats hazard in IDLE.
        resetDut();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        checkOutput("br_flush", {31'd0, flush1}, 32'd1);
        checkOutput("br_bubble", {31'd0, bub1}, 32'd1);
        checkOutput("br_pcwrite", {31'd0, pc1}, 32'd1);
        checkOutput("br_ifidwrite", {31'd0, ifid1}, 32'd1);
        nextCycle();
        checkOutput("br_flush_total", flushCnt1, 32'd1);
        checkOutput("br_stall_total", stall1, 32'd0);

        // Asynchronous reset in the second stall cycle.
        resetDut();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0);
        checkOutput("sc4_c2_busy", {31'd0, busy4}, 32'd1);
        checkOutput("sc4_c2_stall_total", stall4, 32'd1);
        Rst_n = 1'b0;
        #1;
        checkOutput("sc4_rst_pcwrite", {31'd0, pc4}, 32'd1);
        checkOutput("sc4_rst_busy", {31'd0, busy4}, 32'd0);
        checkOutput("sc4_rst_bubble", {31'd0, bub4}, 32'd0);
        checkOutput("sc4_rst_stall_total", stall4, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        nextCycle();
        checkOutput("sc4_post_rst_busy", {31'd0, busy4}, 32'd0);

        // Branch in STALL aborts the stall.
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("sc4_abort_flush", {31'd0, flush4}, 32'd1);
        checkOutput("sc4_abort_pcwrite", {31'd0, pc4}, 32'd1);
        checkOutput("sc4_abort_busy", {31'd0, busy4}, 32'd1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("sc4_idle_busy", {31'd0, busy4}, 32'd0);
        checkOutput("sc4_idle_pcwrite", {31'd0, pc4}, 32'd1);
        checkOutput("sc4_abort_stall_total", stall4, 32'd1);
        checkOutput("sc4_abort_flush_total", flushCnt4, 32'd1);

        // Back-to-back hazards saturate a 4-bit counter at 15.
        resetDut();
        applyStimulus(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        for (int i = 0; i < 14; i++) nextCycle();
        checkOutput("sat_14", {28'd0, stallS}, 32'd14);
        checkOutput("sat_still_stalling", {31'd0, pcS}, 32'd0);
        nextCycle();
        checkOutput("sat_15", {28'd0, stallS}, 32'd15);
        for (int i = 0; i < 5; i++) nextCycle();
        checkOutput("sat_hold", {28'd0, stallS}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
